// File: rtl/axi_stream_cache_pkg.sv
// ============================================================================
// Module      : axi_stream_cache_pkg
// Description : Shared sizing helpers for the AXI-Stream cache FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_stream_cache_pkg;

    localparam int RAM_RD_LAT = 1;

    // Count must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int entry_w(input int dsize, input int usize);
        return dsize + usize + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_stream_cache_ram.sv
// ============================================================================
// Module      : axi_stream_cache_ram
// Description : Simple dual-port single-clock RAM, synchronous read, no bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_stream_cache_ram #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/axi_stream_cache_sc.sv
// ============================================================================
// Module      : axi_stream_cache_sc
// Description : Single-clock AXI-Stream cache FIFO (FWFT, sync-read RAM plus
//               output register). Optional store-and-forward packet mode is
//               enabled by defining AXIS_CACHE_PACKET_MODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_stream_cache_sc
    import axi_stream_cache_pkg::*;
#(
    parameter int DSIZE    = 24,
    parameter int USIZE    = 1,
    parameter int DEPTH    = 512,
    parameter int AF_LEVEL = 496,
    parameter int AE_LEVEL = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      aclken,
    input  logic [DSIZE-1:0]          in_axis_tdata,
    input  logic [USIZE-1:0]          in_axis_tuser,
    input  logic                      in_axis_tlast,
    input  logic                      in_axis_tvalid,
    output logic                      in_axis_tready,
    output logic [DSIZE-1:0]          out_axis_tdata,
    output logic [USIZE-1:0]          out_axis_tuser,
    output logic                      out_axis_tlast,
    output logic                      out_axis_tvalid,
    input  logic                      out_axis_tready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      almost_full,
    output logic                      almost_empty
`ifdef AXIS_CACHE_PACKET_MODE_EN
    ,
    output logic                      pkt_oversize
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = cnt_w(DEPTH);
    localparam int c_EW = entry_w(DSIZE, USIZE);

    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF    = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE    = c_CW'(AE_LEVEL);

    typedef struct packed {
        logic             last;
        logic [USIZE-1:0] user;
        logic [DSIZE-1:0] data;
    } entry_t;

    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_ram_cnt;
    logic            r_rd_valid;
    logic            r_out_valid;
    entry_t          r_out;
    logic            r_in_ready;

    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic            w_rd_issue;
    logic            w_out_valid;
    logic [c_CW-1:0] w_count_nxt;
    entry_t          w_wr_entry;
    entry_t          w_rd_entry;
    logic [c_EW-1:0] w_rd_raw;

    assign w_push = in_axis_tvalid & r_in_ready & aclken;
    assign w_pop  = w_out_valid & out_axis_tready & aclken;

    // RAM output acts as a one-word skid: it is consumed only when the output register frees up.
    assign w_load     = aclken & r_rd_valid & (~r_out_valid | w_pop);
    assign w_rd_issue = aclken & (r_ram_cnt != '0) & (~r_rd_valid | w_load);

    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);

    assign w_wr_entry.last = in_axis_tlast;
    assign w_wr_entry.user = in_axis_tuser;
    assign w_wr_entry.data = in_axis_tdata;
    assign w_rd_entry      = entry_t'(w_rd_raw);

    axi_stream_cache_ram #(
        .WIDTH (c_EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (aclk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wptr),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_rd_raw)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_ram_cnt   <= '0;
            r_rd_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_in_ready  <= 1'b0;
        end else begin
            r_in_ready <= (w_count_nxt < c_DEPTH);
            r_count    <= w_count_nxt;
            r_ram_cnt  <= r_ram_cnt + c_CW'(w_push) - c_CW'(w_rd_issue);
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_rd_issue) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_rd_issue) begin
                r_rd_valid <= 1'b1;
            end else if (w_load) begin
                r_rd_valid <= 1'b0;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out       <= w_rd_entry;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef AXIS_CACHE_PACKET_MODE_EN
    logic [c_CW-1:0] r_pkt_cnt;
    logic            r_fwd;
    logic            r_oversize;
    logic            w_push_last;
    logic            w_pop_last;

    assign w_push_last = w_push & in_axis_tlast;
    assign w_pop_last  = w_pop & r_out.last;
    assign w_out_valid = r_out_valid & ((r_pkt_cnt != '0) | r_fwd);

    // A full store with no complete packet would deadlock; fall back to forwarding until its tlast leaves.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt  <= '0;
            r_fwd      <= 1'b0;
            r_oversize <= 1'b0;
        end else if (aclken) begin
            r_pkt_cnt <= r_pkt_cnt + c_CW'(w_push_last) - c_CW'(w_pop_last);
            if (w_pop_last) begin
                r_fwd <= 1'b0;
            end else if ((r_count == c_DEPTH) && (r_pkt_cnt == '0)) begin
                r_fwd      <= 1'b1;
                r_oversize <= 1'b1;
            end
        end
    end

    assign pkt_oversize = r_oversize;
`else
    assign w_out_valid = r_out_valid;
`endif

    assign in_axis_tready  = r_in_ready;
    assign out_axis_tvalid = w_out_valid;
    assign out_axis_tdata  = r_out.data;
    assign out_axis_tuser  = r_out.user;
    assign out_axis_tlast  = r_out.last;
    assign count           = r_count;
    assign almost_full     = (r_count >= c_AF);
    assign almost_empty    = (r_count <= c_AE);

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_cache_sc.sv
// ============================================================================
// Module      : tb_axi_stream_cache_sc
// Description : Directed self-checking bench for axi_stream_cache_sc (DEPTH=16).
//               Packet-mode scenario is built when AXIS_CACHE_PACKET_MODE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_stream_cache_sc;

    localparam int DSIZE    = 24;
    localparam int USIZE    = 1;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 2;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int NWORDS   = 1000;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             aclken = 1'b1;
    logic [DSIZE-1:0] in_tdata = '0;
    logic [USIZE-1:0] in_tuser = '0;
    logic             in_tlast = 1'b0;
    logic             in_tvalid = 1'b0;
    logic             in_tready;
    logic [DSIZE-1:0] out_tdata;
    logic [USIZE-1:0] out_tuser;
    logic             out_tlast;
    logic             out_tvalid;
    logic             out_tready = 1'b0;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;
`ifdef AXIS_CACHE_PACKET_MODE_EN
    logic             pkt_oversize;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 aclk = ~aclk;

    axi_stream_cache_sc #(
        .DSIZE    (DSIZE),
        .USIZE    (USIZE),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .aclken          (aclken),
        .in_axis_tdata   (in_tdata),
        .in_axis_tuser   (in_tuser),
        .in_axis_tlast   (in_tlast),
        .in_axis_tvalid  (in_tvalid),
        .in_axis_tready  (in_tready),
        .out_axis_tdata  (out_tdata),
        .out_axis_tuser  (out_tuser),
        .out_axis_tlast  (out_tlast),
        .out_axis_tvalid (out_tvalid),
        .out_axis_tready (out_tready),
        .count           (count),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty)
`ifdef AXIS_CACHE_PACKET_MODE_EN
        ,
        .pkt_oversize    (pkt_oversize)
`endif
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (5) tick();
        vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", out_tvalid); end
        vectors++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
        vectors++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
        vectors++; if (in_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", in_tready); end
        vectors++; if (out_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", out_tdata); end
        aresetn = 1'b1;
        tick();
        vectors++; if (in_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b want 1", in_tready); end
    endtask

    task automatic test_single();
        out_tready = 1'b1;
        in_tdata   = 24'hABCDEF;
        in_tuser   = 1'b1;
        in_tlast   = 1'b1;
        in_tvalid  = 1'b1;
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tuser  = 1'b0;
        vectors++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count_n: got %0d want 1", count); end
        vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_n: got %b want 0", out_tvalid); end
        tick();
        vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_n1: got %b want 0", out_tvalid); end
        tick();
        vectors++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid_n2: got %b want 1", out_tvalid); end
        vectors++; if (out_tdata !== 24'hABCDEF) begin errors++; $display("FAIL single_tdata: got %h want abcdef", out_tdata); end
        vectors++; if ({out_tlast, out_tuser} !== 2'b11) begin errors++; $display("FAIL single_last_user: got %b want 11", {out_tlast, out_tuser}); end
        vectors++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count_n2: got %0d want 1", count); end
        tick();
        vectors++; if (count !== '0) begin errors++; $display("FAIL single_count_after: got %0d want 0", count); end
        vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_after: got %b want 0", out_tvalid); end
    endtask

    task automatic test_fill();
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_tlast   = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            in_tdata = DSIZE'(i);
            tick();
            if (i == AF_LEVEL - 2) begin
                vectors++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill_af_below: got %b want 0", almost_full); end
            end
            if (i == AF_LEVEL - 1) begin
                vectors++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_af_at: got %b want 1", almost_full); end
            end
            if (i == DEPTH - 2) begin
                vectors++; if (in_tready !== 1'b1) begin errors++; $display("FAIL fill_tready_15: got %b want 1", in_tready); end
            end
            if (i >= DEPTH - 1) begin
                vectors++; if (in_tready !== 1'b0) begin errors++; $display("FAIL fill_tready_full: got %b want 0", in_tready); end
                vectors++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count_full: got %0d want %0d", count, DEPTH); end
            end
        end
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (out_tvalid !== 1'b1 || out_tdata !== DSIZE'(i)) begin
                errors++;
                $display("FAIL drain_word%0d: got valid=%b data=%h want valid=1 data=%h", i, out_tvalid, out_tdata, DSIZE'(i));
            end
            tick();
        end
        vectors++; if (count !== '0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
        vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL drain_tvalid: got %b want 0", out_tvalid); end
        vectors++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL drain_almost_empty: got %b want 1", almost_empty); end
    endtask

    task automatic test_stream(input bit use_en);
        logic [DSIZE+USIZE:0] q[$];
        logic [DSIZE+USIZE:0] exp_w;
        logic [31:0]          tmp;
        int pushed = 0;
        int popped = 0;
        int model  = 0;
        int cyc    = 0;
        bit p;
        bit o;
        while (popped < NWORDS && cyc < 20000) begin
            aclken     = use_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_tready = ($urandom_range(0, 99) < 70);
            in_tvalid  = (pushed < NWORDS);
            tmp        = pushed * 40503 + 17;
            in_tdata   = tmp[DSIZE-1:0];
            in_tuser   = USIZE'(pushed % 2);
            in_tlast   = ((pushed % 8) == 7);
            p = in_tvalid & in_tready & aclken;
            o = out_tvalid & out_tready & aclken;
            if (o) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_spurious: got data=%h want no word", out_tdata);
                end else begin
                    exp_w = q.pop_front();
                    if ({out_tlast, out_tuser, out_tdata} !== exp_w) begin
                        errors++;
                        $display("FAIL stream_word%0d: got %h want %h", popped, {out_tlast, out_tuser, out_tdata}, exp_w);
                    end
                end
            end
            if (p) q.push_back({in_tlast, in_tuser, in_tdata});
            tick();
            cyc++;
            pushed += int'(p);
            popped += int'(o);
            model  += int'(p) - int'(o);
            vectors++;
            if (count !== CW'(model) || int'(count) > DEPTH) begin
                errors++;
                $display("FAIL stream_count: got %0d want %0d", count, model);
            end
        end
        vectors++;
        if (popped != NWORDS) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words want %0d", popped, NWORDS);
        end
        aclken     = 1'b1;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b0;
    endtask

    task automatic test_reset_mid();
        aclken     = 1'b1;
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_tlast   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_tdata = DSIZE'(24'h300 + i);
            tick();
        end
        aresetn = 1'b0;
        #1;
        vectors++; if (count !== '0) begin errors++; $display("FAIL rstmid_count_async: got %0d want 0", count); end
        tick();
        vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", out_tvalid); end
        vectors++; if (count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
        in_tvalid = 1'b0;
        aresetn   = 1'b1;
        tick();
        vectors++; if (in_tready !== 1'b1) begin errors++; $display("FAIL rstmid_tready: got %b want 1", in_tready); end
        out_tready = 1'b1;
        in_tdata   = 24'h123456;
        in_tlast   = 1'b1;
        in_tvalid  = 1'b1;
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        tick();
        tick();
        vectors++;
        if (out_tvalid !== 1'b1 || out_tdata !== 24'h123456) begin
            errors++;
            $display("FAIL rstmid_fresh: got valid=%b data=%h want valid=1 data=123456", out_tvalid, out_tdata);
        end
        tick();
        vectors++; if (count !== '0) begin errors++; $display("FAIL rstmid_empty: got %0d want 0", count); end
    endtask

`ifdef AXIS_CACHE_PACKET_MODE_EN
    task automatic test_packet();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit p;
        bit o;
        vectors++; if (pkt_oversize !== 1'b0) begin errors++; $display("FAIL pkt_oversize_init: got %b want 0", pkt_oversize); end
        out_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = DSIZE'(24'h500 + i);
            in_tlast  = (i == 4);
            tick();
            if (i < 4) begin
                vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL pkt_hold%0d: got %b want 0", i, out_tvalid); end
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_tvalid !== 1'b1 || out_tdata !== DSIZE'(24'h500 + i)) begin
                errors++;
                $display("FAIL pkt_word%0d: got valid=%b data=%h want valid=1 data=%h", i, out_tvalid, out_tdata, DSIZE'(24'h500 + i));
            end
            tick();
        end
        vectors++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL pkt_end_tvalid: got %b want 0", out_tvalid); end
        out_tready = 1'b0;
        while (got < 20 && cyc < 500) begin
            in_tvalid = (sent < 20);
            in_tdata  = DSIZE'(24'h700 + sent);
            in_tlast  = (sent == 19);
            if (count == CW'(DEPTH)) out_tready = 1'b1;
            p = in_tvalid & in_tready;
            o = out_tvalid & out_tready;
            if (o) begin
                vectors++;
                if (out_tdata !== DSIZE'(24'h700 + got)) begin
                    errors++;
                    $display("FAIL oversize_word%0d: got %h want %h", got, out_tdata, DSIZE'(24'h700 + got));
                end
            end
            tick();
            cyc++;
            sent += int'(p);
            got  += int'(o);
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        vectors++; if (got != 20) begin errors++; $display("FAIL oversize_delivered: got %0d want 20", got); end
        vectors++; if (pkt_oversize !== 1'b1) begin errors++; $display("FAIL oversize_flag: got %b want 1", pkt_oversize); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream(1'b0);
        test_stream(1'b1);
        test_reset_mid();
`ifdef AXIS_CACHE_PACKET_MODE_EN
        test_packet();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
